prefetch_fetch_ctrl: RTL and testbench
======================================

# prefetch_fetch_ctrl

Sequences code fetches for the prefetch unit. Takes the current fetch window (linear address, length, privilege) from the prefetch datapath and issues one outstanding request at a time to the TLB/icache code port. Issue is gated by a byte-credit count of prefetch FIFO free space. Each response is returned as `prefetched_do`/`prefetched_length`, and stale responses after a pipeline flush are discarded.

## Interface
- `FIFO_DEPTH`, 32: prefetch FIFO capacity in bytes; credit reset value.
- `CW`, `$clog2(FIFO_DEPTH)+1`: credit counter width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pr_reset` in 1: full prefetch restart (new CS:EIP); flush.
- `reset_prefetch` in 1: refetch from delivered EIP; flush.
- `prefetch_address` in 32: linear address of next fetch.
- `prefetch_length` in 5: bytes allowed, 0..16; 0 means the limit is reached.
- `prefetch_su` in 1: 1 = user access.
- `prefetched_accept_do` in 1: decoder consumed bytes from the FIFO.
- `prefetched_accept_length` in 4: bytes consumed.
- `req_do` out 1: code request valid.
- `req_ready` in 1: request port accepts when `req_do & req_ready`.
- `req_address` out 32: latched address.
- `req_length` out 5: latched length.
- `req_su` out 1: latched privilege.
- `resp_do` in 1: response strobe, one per accepted request.
- `resp_length` in 5: bytes delivered, 0..`req_length`.
- `resp_fault` in 1: page fault / access error with the response.
- `prefetched_do` out 1: bytes written to FIFO; advances prefetch linear/limit.
- `prefetched_length` out 5: byte count for `prefetched_do`.
- `prefetch_fault_do` out 1: one-cycle fault indication to the FIFO.
- `credit` out CW: current free-byte credit (debug/verification).

## Operation
- `flush = pr_reset | reset_prefetch`.
- States:
  - IDLE: request port idle.
  - REQ: request presented, not yet accepted.
  - WAIT: request accepted, response pending.
  - DRAIN: request accepted before a flush; its response will be discarded.
  - STOP: fault seen; no further fetches.
- IDLE → REQ when `!flush && prefetch_length != 0 && credit >= prefetch_length`.
  - On this transition, latch address, length and su into the `req_*` registers.
- REQ:
  - `req_do=1` with stable `req_*`.
  - On `req_do & req_ready` → WAIT, and credit -= `req_length`.
  - If flush occurs without acceptance → IDLE. The request is withdrawn; this is legal because the target samples only on handshake.
  - If flush and acceptance happen in the same cycle → DRAIN.
- WAIT, on `resp_do`:
  - `prefetched_do` pulses with `prefetched_length = resp_length`.
  - credit += `req_length - resp_length` (unused reservation returned).
  - Next state: `resp_fault` → STOP, with `prefetch_fault_do` pulsed; otherwise IDLE.
- WAIT on flush without `resp_do` → DRAIN.
- WAIT with flush and `resp_do` in the same cycle → response discarded (no `prefetched_do`, no fault), → IDLE.
- DRAIN:
  - `resp_do` is swallowed → IDLE.
  - A further flush keeps the state in DRAIN unless `resp_do` arrives in the same cycle.
- STOP: leaves only on flush → IDLE.
- Credit:
  - Flush sets credit to `FIFO_DEPTH`, because the FIFO is emptied. This overrides all other updates that cycle.
  - Otherwise, issue, refund and `prefetched_accept_*` all apply in the same cycle: `credit + accept + refund - issue`.
  - Credit never exceeds `FIFO_DEPTH` and never goes below 0. Both limits are checked by assertion.

## Timing
- Reset values:
  - state IDLE; credit `FIFO_DEPTH`.
  - `req_do` 0; `req_address`, `req_length`, `req_su` 0.
  - `prefetched_do` 0, `prefetched_length` 0, `prefetch_fault_do` 0.
- All outputs are registered.
- `req_do` rises the cycle after the IDLE issue condition is true.
- `prefetched_do` and `prefetch_fault_do` rise the cycle after `resp_do`. Each is high for exactly one cycle.
- Minimum request-to-request spacing is 1 cycle after a response: resp → IDLE → REQ.
- At most one request is outstanding.
- Asserting `rst_n` low mid-request aborts immediately. Any response arriving after reset is ignored: state IDLE, no `prefetched_do`.

## Structure
- State encodings (5 states, 3 bits) go in the shared defines header next to the other memory-path constants.
- One sub-module, `prefetch_credit`: the CW-bit credit counter with flush, issue, refund and accept inputs.
- The FSM and request latches stay in the top module.

## Test plan
- Basic issue: credit 32, length 16, `req_ready` at once, `resp_length` 16 → `req_do` 1 cycle, `prefetched_do` with 16 the cycle after resp; credit 16, then a second request, then credit 0 and no third request.
- Credit refill: credit 0, `prefetched_accept_length` 8 twice → credit 16 and a new 16-byte request issues next cycle.
- Short response: req 16, resp 5 → `prefetched_length` 5, credit = 32-5 = 27.
- Flush in WAIT: `reset_prefetch` before resp → DRAIN; a later resp with 16 → no `prefetched_do`, credit 32, next request uses the new `prefetch_address`.
- Fault: resp with `resp_fault` 1 and length 0 → `prefetch_fault_do` one pulse, no further `req_do` until `pr_reset`, then a request resumes.
- Limit and simultaneous events: `prefetch_length` 0 → no request. Flush together with `req_ready` in REQ → DRAIN, and the following resp is discarded.

Source files
------------

// File: rtl/prefetch_fetch_ctrl_pkg.sv
// Shared memory-path constants, fetch FSM encodings and the code-request payload
// for the prefetch fetch controller.
package prefetch_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned ACC_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_STOP  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [LEN_W-1:0]  length;
        logic              su;
    } fetch_req_t;

endpackage

// File: rtl/prefetch_credit.sv
// Byte-credit counter tracking prefetch FIFO free space: reserved on issue,
// returned on short responses and decoder consumption, restored on flush.
module prefetch_credit
    import prefetch_fetch_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             issue,
    input  logic [LEN_W-1:0] issue_length,
    input  logic             refund,
    input  logic [LEN_W-1:0] refund_length,
    input  logic             accept,
    input  logic [ACC_W-1:0] accept_length,
    output logic [CW-1:0]    credit
);

    // Signed working width with headroom so under/overflow is observable.
    localparam int unsigned SW = ((CW > LEN_W) ? CW : LEN_W) + 2;

    logic signed [SW-1:0] sum_c;
    logic [CW-1:0]        credit_d;

    always_comb begin
        sum_c = signed'(SW'(credit));
        if (accept) sum_c = sum_c + signed'(SW'(accept_length));
        if (refund) sum_c = sum_c + signed'(SW'(refund_length));
        if (issue)  sum_c = sum_c - signed'(SW'(issue_length));
        credit_d = flush ? CW'(FIFO_DEPTH) : CW'(sum_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit <= CW'(FIFO_DEPTH);
        else        credit <= credit_d;
    end

    a_credit_max: assert property (@(posedge clk) disable iff (!rst_n)
        flush || (sum_c <= signed'(SW'(FIFO_DEPTH))));
    a_credit_min: assert property (@(posedge clk) disable iff (!rst_n)
        flush || (sum_c >= 0));

endmodule

// File: rtl/prefetch_fetch_ctrl.sv
// Prefetch code-fetch sequencer: one outstanding request to the code port,
// gated by FIFO byte credit, with stale responses dropped after a flush.
module prefetch_fetch_ctrl
    import prefetch_fetch_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pr_reset,
    input  logic              reset_prefetch,
    input  logic [ADDR_W-1:0] prefetch_address,
    input  logic [LEN_W-1:0]  prefetch_length,
    input  logic              prefetch_su,
    input  logic              prefetched_accept_do,
    input  logic [ACC_W-1:0]  prefetched_accept_length,
    output logic              req_do,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_address,
    output logic [LEN_W-1:0]  req_length,
    output logic              req_su,
    input  logic              resp_do,
    input  logic [LEN_W-1:0]  resp_length,
    input  logic              resp_fault,
    output logic              prefetched_do,
    output logic [LEN_W-1:0]  prefetched_length,
    output logic              prefetch_fault_do,
    output logic [CW-1:0]     credit
);

    localparam int unsigned CMP_W = (CW > LEN_W) ? CW : LEN_W;

    fetch_state_t     state_q, state_d;
    fetch_req_t       req_q;
    logic             flush_c, handshake_c, credit_ok_c;
    logic             latch_c, issue_c, refund_c, deliver_c, fault_c;
    logic [LEN_W-1:0] refund_len_c;

    assign flush_c     = pr_reset | reset_prefetch;
    assign handshake_c = req_do & req_ready;
    assign credit_ok_c = CMP_W'(credit) >= CMP_W'(prefetch_length);

    // Next-state and per-cycle strobes.
    always_comb begin
        state_d      = state_q;
        latch_c      = 1'b0;
        issue_c      = 1'b0;
        refund_c     = 1'b0;
        deliver_c    = 1'b0;
        fault_c      = 1'b0;
        refund_len_c = req_q.length - resp_length;
        case (state_q)
            ST_IDLE: begin
                if (!flush_c && (prefetch_length != '0) && credit_ok_c) begin
                    state_d = ST_REQ;
                    latch_c = 1'b1;
                end
            end
            ST_REQ: begin
                if (handshake_c) begin
                    issue_c = 1'b1;
                    state_d = flush_c ? ST_DRAIN : ST_WAIT;
                end else if (flush_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (resp_do) begin
                    state_d = ST_IDLE;
                    if (!flush_c) begin
                        deliver_c = 1'b1;
                        refund_c  = 1'b1;
                        if (resp_fault) begin
                            fault_c = 1'b1;
                            state_d = ST_STOP;
                        end
                    end
                end else if (flush_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (resp_do) state_d = ST_IDLE;
            end
            ST_STOP: begin
                if (flush_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Registered request port and FIFO-side strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_do            <= 1'b0;
            req_q             <= '0;
            prefetched_do     <= 1'b0;
            prefetched_length <= '0;
            prefetch_fault_do <= 1'b0;
        end else begin
            req_do            <= (state_d == ST_REQ);
            if (latch_c) req_q <= '{address: prefetch_address, length: prefetch_length, su: prefetch_su};
            prefetched_do     <= deliver_c;
            prefetched_length <= deliver_c ? resp_length : '0;
            prefetch_fault_do <= fault_c;
        end
    end

    assign req_address = req_q.address;
    assign req_length  = req_q.length;
    assign req_su      = req_q.su;

    prefetch_credit #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_credit (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush_c),
        .issue         (issue_c),
        .issue_length  (req_q.length),
        .refund        (refund_c),
        .refund_length (refund_len_c),
        .accept        (prefetched_accept_do),
        .accept_length (prefetched_accept_length),
        .credit        (credit)
    );

endmodule

// File: tb/tb_prefetch_fetch_ctrl.sv
// Bench for prefetch_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a transaction-level model.
module tb_prefetch_fetch_ctrl;

    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pr_reset = 1'b0, reset_prefetch = 1'b0;
    logic [31:0]   prefetch_address = '0;
    logic [4:0]    prefetch_length = '0;
    logic          prefetch_su = 1'b0;
    logic          prefetched_accept_do = 1'b0;
    logic [3:0]    prefetched_accept_length = '0;
    logic          req_ready = 1'b0;
    logic          resp_do = 1'b0;
    logic [4:0]    resp_length = '0;
    logic          resp_fault = 1'b0;
    logic          req_do, req_su, prefetched_do, prefetch_fault_do;
    logic [31:0]   req_address;
    logic [4:0]    req_length, prefetched_length;
    logic [CW-1:0] credit;

    always #5 clk = ~clk;

    prefetch_fetch_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pr_reset(pr_reset), .reset_prefetch(reset_prefetch),
        .prefetch_address(prefetch_address), .prefetch_length(prefetch_length),
        .prefetch_su(prefetch_su), .prefetched_accept_do(prefetched_accept_do),
        .prefetched_accept_length(prefetched_accept_length), .req_do(req_do),
        .req_ready(req_ready), .req_address(req_address), .req_length(req_length),
        .req_su(req_su), .resp_do(resp_do), .resp_length(resp_length),
        .resp_fault(resp_fault), .prefetched_do(prefetched_do),
        .prefetched_length(prefetched_length), .prefetch_fault_do(prefetch_fault_do),
        .credit(credit)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a presented request, an accepted one awaiting its
    // response (possibly stale), and a stopped-after-fault flag.
    bit          m_req, m_out, m_stale, m_stop;
    logic [31:0] m_addr;
    int          m_len;
    bit          m_su;
    int          m_credit = FIFO_DEPTH;
    bit          e_pdo, e_fault;
    int          e_plen;
    int          fifo_bytes = 0;

    task automatic model_step();
        bit fl, was_idle;
        int issue, refund, plen;
        if (!rst_n) begin
            m_req = 0; m_out = 0; m_stale = 0; m_stop = 0;
            m_addr = '0; m_len = 0; m_su = 0; m_credit = FIFO_DEPTH;
            e_pdo = 0; e_fault = 0; e_plen = 0;
            return;
        end
        fl       = pr_reset | reset_prefetch;
        was_idle = !m_req && !m_out && !m_stop;
        plen     = int'(prefetch_length);
        issue = 0; refund = 0; e_pdo = 0; e_fault = 0; e_plen = 0;
        if (m_out && resp_do) begin
            if (!m_stale && !fl) begin
                e_pdo  = 1;
                e_plen = int'(resp_length);
                refund = m_len - int'(resp_length);
                fifo_bytes += int'(resp_length);
                if (resp_fault) begin
                    e_fault = 1;
                    m_stop  = 1;
                end
            end
            m_out = 0; m_stale = 0;
        end else if (m_out && fl) begin
            m_stale = 1;
        end
        if (m_req) begin
            if (req_ready) begin
                issue = m_len; m_out = 1; m_stale = fl; m_req = 0;
            end else if (fl) begin
                m_req = 0;
            end
        end
        if (fl) m_stop = 0;
        if (was_idle && !fl && plen != 0 && m_credit >= plen) begin
            m_req = 1; m_addr = prefetch_address; m_len = plen; m_su = prefetch_su;
        end
        if (fl) m_credit = FIFO_DEPTH;
        else    m_credit = m_credit + (prefetched_accept_do ? int'(prefetched_accept_length) : 0)
                           + refund - issue;
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("req_do", 32'(req_do), 32'(m_req));
            if (m_req) begin
                chk("req_address", req_address, m_addr);
                chk("req_length", 32'(req_length), 32'(m_len));
                chk("req_su", 32'(req_su), 32'(m_su));
            end
            chk("prefetched_do", 32'(prefetched_do), 32'(e_pdo));
            if (e_pdo) chk("prefetched_length", 32'(prefetched_length), 32'(e_plen));
            chk("prefetch_fault_do", 32'(prefetch_fault_do), 32'(e_fault));
            chk("credit", 32'(credit), 32'(m_credit));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Target-side responder state for randomized traffic.
    bit tgt_busy;
    int tgt_cnt, tgt_len;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pr_reset = 0; reset_prefetch = 0; prefetch_address = '0; prefetch_length = '0;
        prefetch_su = 0; prefetched_accept_do = 0; prefetched_accept_length = '0;
        req_ready = 0; resp_do = 0; resp_length = '0; resp_fault = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        fifo_bytes = 0; tgt_busy = 0;
        repeat (2) nxt();
        rst_n = 1;
    endtask

    task automatic rand_drive();
        int r, mx;
        resp_do = 0; resp_fault = 0; resp_length = '0;
        if (tgt_busy) begin
            if (tgt_cnt == 0) begin
                resp_do     = 1;
                resp_length = 5'($urandom_range(0, tgt_len));
                resp_fault  = ($urandom_range(0, 15) == 0);
                tgt_busy    = 0;
            end else begin
                tgt_cnt--;
            end
        end
        r = int'($urandom_range(0, 99));
        pr_reset       = (r < 2);
        reset_prefetch = (r >= 2 && r < 6);
        req_ready      = ($urandom_range(0, 2) != 0);
        if (req_do && req_ready) begin
            tgt_busy = 1;
            tgt_cnt  = int'($urandom_range(0, 3));
            tgt_len  = int'(req_length);
        end
        r = int'($urandom_range(0, 19));
        prefetch_length  = 5'((r > 16) ? 16 : r);
        prefetch_address = $urandom;
        prefetch_su      = 1'($urandom_range(0, 1));
        prefetched_accept_do = 0; prefetched_accept_length = '0;
        if (pr_reset || reset_prefetch) begin
            fifo_bytes = 0;
        end else if (fifo_bytes > 0 && $urandom_range(0, 1) == 1) begin
            mx = (fifo_bytes > 15) ? 15 : fifo_bytes;
            r  = int'($urandom_range(1, mx));
            prefetched_accept_do     = 1;
            prefetched_accept_length = 4'(r);
            fifo_bytes -= r;
        end
    endtask

    initial begin : stim
        clear_inputs();
        repeat (3) nxt();
        chk("reset credit", 32'(credit), 32);
        chk("reset req_do", 32'(req_do), 0);
        chk("reset req_address", req_address, 0);
        chk("reset prefetched_do", 32'(prefetched_do), 0);
        rst_n = 1;

        // Basic issue, credit exhaustion and refill.
        prefetch_length = 16; prefetch_address = 32'h0000_1000; prefetch_su = 1; req_ready = 1;
        nxt(); chk("basic req_do", 32'(req_do), 1); chk("basic req_address", req_address, 32'h1000);
        nxt(); chk("basic req_do one cycle", 32'(req_do), 0); chk("basic credit after issue", 32'(credit), 16);
        req_ready = 0; resp_do = 1; resp_length = 16;
        nxt(); chk("basic prefetched_do", 32'(prefetched_do), 1);
        chk("basic prefetched_length", 32'(prefetched_length), 16);
        resp_do = 0; req_ready = 1;
        nxt(); chk("second req_do", 32'(req_do), 1);
        nxt(); chk("credit zero", 32'(credit), 0);
        req_ready = 0; resp_do = 1; resp_length = 16;
        nxt(); resp_do = 0;
        nxt(); chk("no third req", 32'(req_do), 0);
        prefetched_accept_do = 1; prefetched_accept_length = 8;
        nxt(); chk("refill credit 8", 32'(credit), 8);
        nxt(); chk("refill credit 16", 32'(credit), 16); chk("refill no req yet", 32'(req_do), 0);
        prefetched_accept_do = 0;
        nxt(); chk("refill req_do", 32'(req_do), 1);

        // Short response returns the unused reservation.
        do_reset();
        prefetch_length = 16; req_ready = 1;
        nxt(); nxt();
        req_ready = 0; resp_do = 1; resp_length = 5;
        nxt(); chk("short prefetched_length", 32'(prefetched_length), 5);
        chk("short credit", 32'(credit), 27);
        resp_do = 0; prefetch_length = 0;

        // Flush while waiting: stale response swallowed, refetch from new address.
        do_reset();
        prefetch_length = 16; prefetch_address = 32'h0000_A000; req_ready = 1;
        nxt(); nxt();
        req_ready = 0; reset_prefetch = 1; prefetch_address = 32'h0000_B000;
        nxt(); chk("drain credit", 32'(credit), 32);
        reset_prefetch = 0;
        nxt(); chk("drain no req", 32'(req_do), 0);
        resp_do = 1; resp_length = 16;
        nxt(); chk("drain swallowed", 32'(prefetched_do), 0); chk("drain credit kept", 32'(credit), 32);
        resp_do = 0;
        nxt(); chk("refetch req_do", 32'(req_do), 1); chk("refetch address", req_address, 32'hB000);

        // Fault stops fetching until pr_reset.
        do_reset();
        prefetch_length = 16; req_ready = 1;
        nxt(); nxt();
        req_ready = 0; resp_do = 1; resp_length = 0; resp_fault = 1;
        nxt(); chk("fault pulse", 32'(prefetch_fault_do), 1);
        resp_do = 0; resp_fault = 0; req_ready = 1;
        nxt(); chk("fault single pulse", 32'(prefetch_fault_do), 0);
        for (int i = 0; i < 5; i++) begin
            nxt(); chk("stopped no req", 32'(req_do), 0);
        end
        pr_reset = 1;
        nxt(); pr_reset = 0;
        nxt(); chk("resume after pr_reset", 32'(req_do), 1);

        // Zero length limit, then flush coinciding with acceptance.
        do_reset();
        prefetch_length = 0; req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            nxt(); chk("limit no req", 32'(req_do), 0);
        end
        prefetch_length = 16;
        nxt(); chk("pre-flush req_do", 32'(req_do), 1);
        reset_prefetch = 1;
        nxt(); chk("flush+accept credit", 32'(credit), 32); chk("flush+accept req_do", 32'(req_do), 0);
        reset_prefetch = 0; req_ready = 0; resp_do = 1; resp_length = 16;
        nxt(); chk("flush+accept discard", 32'(prefetched_do), 0);
        resp_do = 0;

        // Asynchronous reset while a response is pending.
        do_reset();
        prefetch_length = 16; req_ready = 1;
        nxt(); nxt();
        req_ready = 0; prefetch_length = 0;
        rst_n = 0;
        #2;
        chk("async reset credit", 32'(credit), 32);
        nxt();
        rst_n = 1; resp_do = 1; resp_length = 16;
        nxt(); chk("post-reset resp ignored", 32'(prefetched_do), 0);
        resp_do = 0;

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rand_drive();
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
